dma_dsc_cache_rd_ctrl: RTL and testbench

//  Read-side controller for the DMA descriptor cache RAM. Accepts descriptor-index requests

---
 rtl/dma_dsc_cache_rd_ctrl_pkg.sv | 16 +
 rtl/dma_dsc_cache_rd_ctrl_if.sv | 34 +++
 rtl/dma_dsc_cache_rd_ctrl_chk.sv | 23 ++
 rtl/dma_dsc_cache_rd_ctrl_out_fifo.sv | 81 ++++++++
 rtl/dma_dsc_cache_rd_ctrl.sv | 131 +++++++++++++
 tb/tb_dma_dsc_cache_rd_ctrl.sv | 278 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/dma_dsc_cache_rd_ctrl_pkg.sv
// Shared descriptor-cache constants and the descriptor entry type used by the
// cache write controller, this read controller and the descriptor decoder.
package dma_dsc_pkg;

    localparam int DSC_WIDTH      = 128;
    localparam int DSC_ADDR_WIDTH = 7;
    localparam int DSC_RD_LATENCY = 2;
    localparam int DSC_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DSC_WIDTH-1:0]      data;
        logic [DSC_ADDR_WIDTH-1:0] idx;
        logic                      err;
    } dsc_entry_t;

endpackage

// File: rtl/dma_dsc_cache_rd_ctrl_if.sv
// Bundle of the scheduler request, cache read port and decode-stage handshake.
// The slave modport is the read controller's view; master is the environment's.
interface dma_dsc_cache_rd_ctrl_if
    import dma_dsc_pkg::*;
#(
    parameter int WIDTH      = DSC_WIDTH,
    parameter int ADDR_WIDTH = DSC_ADDR_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  flush;
    logic                  ram_ren;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [WIDTH-1:0]      ram_rdata;
    logic                  ram_db_det;
    logic                  dsc_valid;
    logic                  dsc_ready;
    logic [WIDTH-1:0]      dsc_data;
    logic [ADDR_WIDTH-1:0] dsc_idx;
    logic                  dsc_err;

    modport slave (
        input  req_valid, req_idx, flush, ram_rdata, ram_db_det, dsc_ready,
        output req_ready, ram_ren, ram_raddr, dsc_valid, dsc_data, dsc_idx, dsc_err
    );

    modport master (
        output req_valid, req_idx, flush, ram_rdata, ram_db_det, dsc_ready,
        input  req_ready, ram_ren, ram_raddr, dsc_valid, dsc_data, dsc_idx, dsc_err
    );

endinterface

// File: rtl/dma_dsc_cache_rd_ctrl_chk.sv
// Occupancy invariants of the descriptor read controller.
module dma_dsc_cache_rd_ctrl_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 2,
    parameter int CW         = 3,
    parameter int IW         = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] fifo_count,
    input logic [IW-1:0] inflight_count
);

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        32'(fifo_count) <= FIFO_DEPTH);

    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(inflight_count) <= RD_LATENCY);

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(fifo_count) + 32'(inflight_count)) <= FIFO_DEPTH);

endmodule

// File: rtl/dma_dsc_cache_rd_ctrl_out_fifo.sv
// Synchronous output FIFO of descriptor entries with clear and occupancy count.
// The head is read straight out of flop storage so it never glitches under stall.
module dma_dsc_out_fifo
    import dma_dsc_pkg::*;
#(
    parameter int  DEPTH = DSC_FIFO_DEPTH,
    parameter type T     = dsc_entry_t,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop_s;

    // Pointer, count and storage update; clear overrides push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        do_pop_s = pop && (cnt_q != '0);
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (do_pop_s) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push, do_pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign valid = (cnt_q != '0);
    assign count = cnt_q;

endmodule

// File: rtl/dma_dsc_cache_rd_ctrl.sv
// Read-side controller for the DMA descriptor cache: issues index reads to the RAM,
// tracks them through the read latency and queues the returns for the decode stage.
module dma_dsc_cache_rd_ctrl
    import dma_dsc_pkg::*;
#(
    parameter int WIDTH      = DSC_WIDTH,
    parameter int ADDR_WIDTH = DSC_ADDR_WIDTH,
    parameter int RD_LATENCY = DSC_RD_LATENCY,
    parameter int FIFO_DEPTH = DSC_FIFO_DEPTH
) (
    input logic                    clk,
    input logic                    rst_n,
    dma_dsc_cache_rd_ctrl_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LATENCY + 1);

    typedef struct packed {
        logic [WIDTH-1:0]      data;
        logic [ADDR_WIDTH-1:0] idx;
        logic                  err;
    } entry_t;

    logic                  live_q, live_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] idx_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] idx_d [RD_LATENCY];
    logic                  issue_s;
    logic                  req_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_valid_s;
    logic [CW-1:0]         fifo_count_s;
    logic [IW-1:0]         inflight_s;
    logic [CW:0]           occ_s;
    entry_t                push_entry_s;
    entry_t                head_s;

    // Requests stay blocked until the first edge after reset release.
    always_comb begin
        live_d = 1'b1;
    end

    // Credit check: a pop in this cycle is deliberately not counted back.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + IW'(vld_q[i]);
        end
        occ_s       = {1'b0, fifo_count_s} + (CW+1)'(inflight_s);
        req_ready_s = live_q && !bus.flush && (occ_s < (CW+1)'(FIFO_DEPTH));
        issue_s     = bus.req_valid && req_ready_s;
    end

    // In-flight pipe mirrors the RAM latency; flush drops every outstanding read.
    always_comb begin
        vld_d = vld_q;
        idx_d = idx_q;
        if (bus.flush) begin
            vld_d = '0;
        end else begin
            vld_d[0] = issue_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
        idx_d[0] = bus.req_idx;
        for (int i = 1; i < RD_LATENCY; i++) begin
            idx_d[i] = idx_q[i-1];
        end
    end

    // Request-enable and in-flight pipe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            vld_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            live_q <= live_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
        end
    end

    assign push_s            = vld_q[RD_LATENCY-1] && !bus.flush;
    assign pop_s             = fifo_valid_s && bus.dsc_ready;
    assign push_entry_s.data = bus.ram_rdata;
    assign push_entry_s.idx  = idx_q[RD_LATENCY-1];
    assign push_entry_s.err  = bus.ram_db_det;

    dma_dsc_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.flush),
        .push  (push_s),
        .din   (push_entry_s),
        .pop   (pop_s),
        .dout  (head_s),
        .valid (fifo_valid_s),
        .count (fifo_count_s)
    );

    dma_dsc_cache_rd_ctrl_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LATENCY (RD_LATENCY),
        .CW         (CW),
        .IW         (IW)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_count     (fifo_count_s),
        .inflight_count (inflight_s)
    );

    // The RAM registers its own address, so the read port is driven straight through.
    assign bus.req_ready = req_ready_s;
    assign bus.ram_ren   = issue_s;
    assign bus.ram_raddr = live_q ? bus.req_idx : '0;
    assign bus.dsc_valid = fifo_valid_s;
    assign bus.dsc_data  = head_s.data;
    assign bus.dsc_idx   = head_s.idx;
    assign bus.dsc_err   = head_s.err;

endmodule

// File: tb/tb_dma_dsc_cache_rd_ctrl.sv
// Directed bench for the descriptor cache read controller with a 2-cycle RAM model.
module tb_dma_dsc_cache_rd_ctrl;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;
    int   cyc;
    int   iss0;
    int   nacc;
    logic err_en;
    logic [6:0] err_idx;

    logic       ram_en1;
    logic [6:0] ram_addr1;

    typedef struct {
        int         cyc;
        logic [127:0] data;
        logic [6:0] idx;
        logic       err;
    } rec_t;

    rec_t got[$];

    dma_dsc_cache_rd_ctrl_if #(.WIDTH(128), .ADDR_WIDTH(7)) bus ();

    dma_dsc_cache_rd_ctrl #(
        .WIDTH      (128),
        .ADDR_WIDTH (7),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: address register then data register; word i holds i*0x11.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en1        <= 1'b0;
            ram_addr1      <= 7'd0;
            bus.ram_rdata  <= 128'd0;
            bus.ram_db_det <= 1'b0;
        end else begin
            ram_en1   <= bus.ram_ren;
            ram_addr1 <= bus.ram_raddr;
            if (ram_en1) begin
                bus.ram_rdata  <= 128'(ram_addr1) * 128'd17;
                bus.ram_db_det <= err_en && (ram_addr1 == err_idx);
            end else begin
                bus.ram_db_det <= 1'b0;
            end
        end
    end

    // Record every accepted descriptor with the number of the edge that takes it.
    always @(negedge clk) begin
        rec_t r;
        if (rst_n && bus.dsc_valid && bus.dsc_ready) begin
            r.cyc  = cyc + 1;
            r.data = bus.dsc_data;
            r.idx  = bus.dsc_idx;
            r.err  = bus.dsc_err;
            got.push_back(r);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errs = 0; checks = 0; cyc = 0; iss0 = 0; nacc = 0;
        err_en = 1'b0; err_idx = 7'd0;
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_idx = 7'd9; bus.flush = 1'b0; bus.dsc_ready = 1'b0;

        // 1: reset holds everything quiet even with a request pending
        repeat (3) step();
        #1;
        chk("rst_ren", 160'(bus.ram_ren), 160'd0);
        chk("rst_req_ready", 160'(bus.req_ready), 160'd0);
        chk("rst_dsc_valid", 160'(bus.dsc_valid), 160'd0);
        chk("rst_dsc_data", 160'(bus.dsc_data), 160'd0);
        chk("rst_raddr", 160'(bus.ram_raddr), 160'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        #1;
        chk("post_rst_ready", 160'(bus.req_ready), 160'd1);

        // 2: streaming idx 0..7
        bus.dsc_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_idx = 7'(i);
            #1;
            chk("stream_ready", 160'(bus.req_ready), 160'd1);
            chk("stream_raddr", 160'(bus.ram_raddr), 160'(i));
            if (i == 0) iss0 = cyc + 1;
            step();
        end
        bus.req_valid = 1'b0;
        repeat (6) step();
        chk("stream_count", 160'(got.size()), 160'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got.size()) begin
                chk("stream_idx", 160'(got[k].idx), 160'(k));
                chk("stream_data", 160'(got[k].data), 160'(k * 17));
                if (k == 0) chk("stream_first_lat", 160'(got[0].cyc - iss0), 160'd3);
                else chk("stream_gap", 160'(got[k].cyc - got[k-1].cyc), 160'd1);
            end
        end

        // 3: back-pressure
        got.delete();
        bus.dsc_ready = 1'b0;
        nacc = 0;
        repeat (10) begin
            bus.req_valid = 1'b1;
            bus.req_idx = 7'(16 + nacc);
            #1;
            if (bus.ram_ren) nacc++;
            step();
        end
        chk("bp_issues", 160'(nacc), 160'd4);
        chk("bp_ready_low", 160'(bus.req_ready), 160'd0);
        chk("bp_valid", 160'(bus.dsc_valid), 160'd1);
        chk("bp_head_idx", 160'(bus.dsc_idx), 160'd16);
        step(); step();
        chk("bp_data_stable", 160'(bus.dsc_data), 160'd272);
        chk("bp_idx_stable", 160'(bus.dsc_idx), 160'd16);
        bus.dsc_ready = 1'b1;
        for (int t = 0; t < 40 && nacc < 8; t++) begin
            bus.req_valid = 1'b1;
            bus.req_idx = 7'(16 + nacc);
            #1;
            if (bus.ram_ren) nacc++;
            step();
        end
        bus.req_valid = 1'b0;
        chk("bp_total_issues", 160'(nacc), 160'd8);
        repeat (8) step();
        chk("bp_count", 160'(got.size()), 160'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got.size()) begin
                chk("bp_idx", 160'(got[k].idx), 160'(16 + k));
                chk("bp_data", 160'(got[k].data), 160'((16 + k) * 17));
            end
        end

        // 4: flush with two queued and two in flight
        got.delete();
        bus.dsc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_idx = 7'(40 + i);
            #1;
            chk("fl_issue", 160'(bus.ram_ren), 160'd1);
            step();
        end
        chk("fl_pre_valid", 160'(bus.dsc_valid), 160'd1);
        bus.req_idx = 7'd99;
        bus.flush = 1'b1;
        #1;
        chk("fl_ren_blocked", 160'(bus.ram_ren), 160'd0);
        step();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("fl_valid_cleared", 160'(bus.dsc_valid), 160'd0);
        bus.dsc_ready = 1'b1;
        repeat (5) step();
        chk("fl_no_late", 160'(got.size()), 160'd0);
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        #1;
        chk("fl_idle_ready", 160'(bus.req_ready), 160'd0);
        chk("fl_idle_ren", 160'(bus.ram_ren), 160'd0);
        step();
        bus.flush = 1'b0;
        bus.req_idx = 7'd5;
        #1;
        chk("fl_new_issue", 160'(bus.ram_ren), 160'd1);
        step();
        bus.req_valid = 1'b0;
        repeat (6) step();
        chk("fl_new_count", 160'(got.size()), 160'd1);
        if (got.size() > 0) begin
            chk("fl_new_idx", 160'(got[0].idx), 160'd5);
            chk("fl_new_data", 160'(got[0].data), 160'd85);
        end

        // 5: double-bit error flag travels with idx 3 only
        got.delete();
        err_en = 1'b1;
        err_idx = 7'd3;
        for (int i = 2; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_idx = 7'(i);
            step();
        end
        bus.req_valid = 1'b0;
        repeat (6) step();
        chk("err_count", 160'(got.size()), 160'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                chk("err_idx", 160'(got[k].idx), 160'(k + 2));
                chk("err_flag", 160'(got[k].err), (k == 1) ? 160'd1 : 160'd0);
            end
        end

        // 6: asynchronous reset mid-stream
        got.delete();
        err_en = 1'b0;
        bus.dsc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_idx = 7'(60 + i);
            step();
        end
        bus.req_idx = 7'd64;
        #1;
        chk("ar_pre_valid", 160'(bus.dsc_valid), 160'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 160'(bus.dsc_valid), 160'd0);
        chk("ar_data", 160'(bus.dsc_data), 160'd0);
        chk("ar_idx", 160'(bus.dsc_idx), 160'd0);
        chk("ar_ready", 160'(bus.req_ready), 160'd0);
        chk("ar_ren", 160'(bus.ram_ren), 160'd0);
        step(); step();
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        bus.dsc_ready = 1'b1;
        repeat (5) step();
        chk("ar_no_stale", 160'(got.size()), 160'd0);
        bus.req_valid = 1'b1;
        bus.req_idx = 7'd7;
        #1;
        chk("ar_new_issue", 160'(bus.ram_ren), 160'd1);
        step();
        bus.req_valid = 1'b0;
        repeat (6) step();
        chk("ar_new_count", 160'(got.size()), 160'd1);
        if (got.size() > 0) begin
            chk("ar_new_idx", 160'(got[0].idx), 160'd7);
            chk("ar_new_data", 160'(got[0].data), 160'd119);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
